// File: rtl/imem_burst_if.sv
// Fetch and debug burst-load signal bundle for imem_burst.
// The slave modport is the memory side; master is the core/debugger side.
interface imem_burst_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 256
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_valid;
    logic [XLEN-1:0]   fetch_instr;
    logic              fetch_err;
    logic              fetch_stall;

    logic              dbg_start;
    logic [31:0]       dbg_base;
    logic              dbg_wvalid;
    logic [XLEN-1:0]   dbg_wdata;
    logic              dbg_last;
    logic              dbg_wready;
    logic              dbg_busy;
    logic              dbg_done;
    logic              dbg_err;
    logic [ADDR_W:0]   dbg_count;

    modport slave (
        input  fetch_req, fetch_addr, dbg_start, dbg_base, dbg_wvalid, dbg_wdata, dbg_last,
        output fetch_valid, fetch_instr, fetch_err, fetch_stall,
               dbg_wready, dbg_busy, dbg_done, dbg_err, dbg_count
    );

    modport master (
        output fetch_req, fetch_addr, dbg_start, dbg_base, dbg_wvalid, dbg_wdata, dbg_last,
        input  fetch_valid, fetch_instr, fetch_err, fetch_stall,
               dbg_wready, dbg_busy, dbg_done, dbg_err, dbg_count
    );
endinterface

// File: rtl/imem_burst.sv
// Instruction memory with one-cycle registered fetch and a debug burst-load engine.
// Fetch is refused whenever the load engine is not idle, so the core never sees a partial image.
module imem_burst #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 256,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input logic         clk,
    input logic         nrst,
    imem_burst_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [XLEN-1:0]   mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              derr_q, derr_d;
    logic              done_q, done_d;
    logic              fvld_q, ferr_q;
    logic [XLEN-1:0]   finstr_q;
    logic              f_acc, f_ok, b_ok, beat;

    // Range checks use the whole upper address so aliases above DEPTH are rejected.
    assign f_acc = bus.fetch_req && (state_q == IDLE);
    assign f_ok  = (bus.fetch_addr[1:0] == 2'b00) &&
                   ({2'b00, bus.fetch_addr[31:2]} < 32'(DEPTH));
    assign b_ok  = (bus.dbg_base[1:0] == 2'b00) &&
                   ({2'b00, bus.dbg_base[31:2]} < 32'(DEPTH));
    assign beat  = (state_q == LOAD) && bus.dbg_wvalid;

    always_ff @(posedge clk) begin
        if (beat) mem[ptr_q] <= bus.dbg_wdata;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fvld_q   <= 1'b0;
            ferr_q   <= 1'b0;
            finstr_q <= NOP_INSTR;
        end else begin
            fvld_q <= f_acc;
            if (f_acc) begin
                ferr_q   <= !f_ok;
                finstr_q <= f_ok ? mem[bus.fetch_addr[ADDR_W+1:2]] : NOP_INSTR;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        derr_d  = derr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dbg_start) begin
                    cnt_d = '0;
                    if (b_ok) begin
                        ptr_d   = bus.dbg_base[ADDR_W+1:2];
                        derr_d  = 1'b0;
                        state_d = LOAD;
                    end else begin
                        derr_d = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (bus.dbg_wvalid) begin
                    cnt_d = cnt_q + (ADDR_W+1)'(1);
                    if (bus.dbg_last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (ptr_q == ADDR_W'(DEPTH-1)) begin
                        // Top of memory reached without a last beat: truncate rather than wrap.
                        derr_d  = 1'b1;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            derr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            derr_q  <= derr_d;
            done_q  <= done_d;
        end
    end

    assign bus.fetch_valid = fvld_q;
    assign bus.fetch_instr = finstr_q;
    assign bus.fetch_err   = ferr_q;
    assign bus.fetch_stall = (state_q != IDLE);
    assign bus.dbg_busy    = (state_q != IDLE);
    assign bus.dbg_wready  = (state_q == LOAD);
    assign bus.dbg_done    = done_q;
    assign bus.dbg_err     = derr_q;
    assign bus.dbg_count   = cnt_q;
endmodule

// File: tb/tb_imem_burst.sv
// Directed bench for imem_burst: a transaction-level model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_imem_burst;
    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    imem_burst_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

    imem_burst #(.XLEN(32), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: memory image plus a description of the current burst (base word, room, beats taken).
    logic [31:0] mdl [DEPTH];
    bit          known [DEPTH];
    int          m_phase;      // 0 idle, 1 accepting beats, 2 end-of-burst cycle
    int          m_base, m_room, m_cnt;
    logic        m_valid, m_ierr, m_done, m_derr, m_known;
    logic [31:0] m_instr;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_valid <= 1'b0;
            m_ierr  <= 1'b0;
            m_instr <= NOP;
            m_known <= 1'b1;
            m_done  <= 1'b0;
            m_derr  <= 1'b0;
        end else begin
            m_valid <= bus.fetch_req && (m_phase == 0);
            if (bus.fetch_req && m_phase == 0) begin
                if (bus.fetch_addr % 4 != 0 || bus.fetch_addr / 4 >= DEPTH) begin
                    m_ierr  <= 1'b1;
                    m_instr <= NOP;
                    m_known <= 1'b1;
                end else begin
                    m_ierr  <= 1'b0;
                    m_instr <= mdl[bus.fetch_addr / 4];
                    m_known <= known[bus.fetch_addr / 4];
                end
            end
            m_done <= 1'b0;
            if (m_phase == 2) begin
                m_phase <= 0;
            end else if (m_phase == 1) begin
                if (bus.dbg_wvalid) begin
                    mdl[m_base + m_cnt]   <= bus.dbg_wdata;
                    known[m_base + m_cnt] <= 1'b1;
                    m_cnt <= m_cnt + 1;
                    if (bus.dbg_last || m_cnt + 1 == m_room) begin
                        m_phase <= 2;
                        m_done  <= 1'b1;
                        if (!bus.dbg_last) m_derr <= 1'b1;
                    end
                end
            end else if (bus.dbg_start) begin
                m_cnt <= 0;
                if (bus.dbg_base % 4 == 0 && bus.dbg_base / 4 < DEPTH) begin
                    m_base  <= int'(bus.dbg_base / 4);
                    m_room  <= DEPTH - int'(bus.dbg_base / 4);
                    m_derr  <= 1'b0;
                    m_phase <= 1;
                end else begin
                    m_derr <= 1'b1;
                    m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("fetch_valid", 32'(bus.fetch_valid), 32'(m_valid));
        chk("fetch_stall", 32'(bus.fetch_stall), 32'(m_phase != 0));
        chk("dbg_busy",    32'(bus.dbg_busy),    32'(m_phase != 0));
        chk("dbg_wready",  32'(bus.dbg_wready),  32'(m_phase == 1));
        chk("dbg_done",    32'(bus.dbg_done),    32'(m_done));
        chk("dbg_err",     32'(bus.dbg_err),     32'(m_derr));
        chk("dbg_count",   32'(bus.dbg_count),   32'(m_cnt));
        if (m_valid) chk("fetch_err", 32'(bus.fetch_err), 32'(m_ierr));
        if (m_known) chk("fetch_instr", bus.fetch_instr, m_instr);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        bus.dbg_wvalid = 1'b1;
        bus.dbg_wdata  = d;
        bus.dbg_last   = last;
    endtask

    initial begin
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.dbg_start  = 1'b0;
        bus.dbg_base   = '0;
        bus.dbg_wvalid = 1'b0;
        bus.dbg_wdata  = '0;
        bus.dbg_last   = 1'b0;
        #2 nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        cyc();
        chk("rst_stall", 32'(bus.fetch_stall), 32'd0);
        chk("rst_instr", bus.fetch_instr, 32'h00000013);
        chk("rst_count", 32'(bus.dbg_count), 32'd0);

        // Burst of 4 at 0x40, with a fetch held throughout that must be refused.
        bus.dbg_start = 1'b1; bus.dbg_base = 32'h40;
        cyc();
        bus.dbg_start = 1'b0;
        chk("load_wready", 32'(bus.dbg_wready), 32'd1);
        fetch(32'h40);
        for (int i = 0; i < 4; i++) begin
            beat(32'hA0 + 32'(i), i == 3);
            cyc();
            if (i == 0) begin
                chk("load_stall", 32'(bus.fetch_stall), 32'd1);
                chk("load_refused", 32'(bus.fetch_valid), 32'd0);
            end
        end
        bus.dbg_wvalid = 1'b0; bus.dbg_last = 1'b0;
        chk("burst_done", 32'(bus.dbg_done), 32'd1);
        chk("burst_count", 32'(bus.dbg_count), 32'd4);
        chk("burst_err", 32'(bus.dbg_err), 32'd0);
        cyc();
        chk("done_refused", 32'(bus.fetch_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            fetch(32'h40 + 32'(4 * i));
            cyc();
            chk("b2b_valid", 32'(bus.fetch_valid), 32'd1);
            chk("b2b_instr", bus.fetch_instr, 32'hA0 + 32'(i));
        end
        bus.fetch_req = 1'b0;

        // Start and fetch in the same idle cycle, preloading words 0..2.
        bus.dbg_start = 1'b1; bus.dbg_base = 32'h0;
        fetch(32'h44);
        cyc();
        bus.dbg_start = 1'b0; bus.fetch_req = 1'b0;
        chk("start_fetch", bus.fetch_instr, 32'hA1);
        chk("start_wready", 32'(bus.dbg_wready), 32'd1);
        beat(32'h11, 1'b0); cyc();
        beat(32'h22, 1'b0); cyc();
        beat(32'h33, 1'b1); cyc();
        bus.dbg_wvalid = 1'b0; bus.dbg_last = 1'b0;
        cyc();

        // Misaligned and out-of-range fetches; last legal word is in range.
        fetch(32'h42);  cyc();
        chk("misalign_err", 32'(bus.fetch_err), 32'd1);
        chk("misalign_nop", bus.fetch_instr, NOP);
        fetch(32'h400); cyc();
        chk("range_err", 32'(bus.fetch_err), 32'd1);
        fetch(32'h3FC); cyc();
        chk("top_ok", 32'(bus.fetch_err), 32'd0);
        bus.fetch_req = 1'b0;

        // Truncated burst at the top of memory.
        bus.dbg_start = 1'b1; bus.dbg_base = 32'h3F8;
        cyc();
        bus.dbg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            beat(32'hC0 + 32'(i), 1'b0);
            cyc();
            if (i == 1) begin
                chk("trunc_done", 32'(bus.dbg_done), 32'd1);
                chk("trunc_err", 32'(bus.dbg_err), 32'd1);
                chk("trunc_count", 32'(bus.dbg_count), 32'd2);
            end
        end
        bus.dbg_wvalid = 1'b0;
        cyc();
        fetch(32'h3F8); cyc(); chk("trunc_w254", bus.fetch_instr, 32'hC0);
        fetch(32'h3FC); cyc(); chk("trunc_w255", bus.fetch_instr, 32'hC1);
        fetch(32'h0);   cyc(); chk("no_wrap_w0", bus.fetch_instr, 32'h11);
        bus.fetch_req = 1'b0;

        // Bad base: error and done pulse, no load, error held afterwards.
        bus.dbg_start = 1'b1; bus.dbg_base = 32'h41;
        cyc();
        bus.dbg_start = 1'b0;
        chk("badbase_done", 32'(bus.dbg_done), 32'd1);
        chk("badbase_err", 32'(bus.dbg_err), 32'd1);
        chk("badbase_busy", 32'(bus.dbg_busy), 32'd0);
        chk("badbase_count", 32'(bus.dbg_count), 32'd0);
        cyc();
        chk("err_held", 32'(bus.dbg_err), 32'd1);
        fetch(32'h40); cyc(); chk("badbase_nowrite", bus.fetch_instr, 32'hA0);
        bus.fetch_req = 1'b0;

        // Reset in the middle of a burst after two beats.
        bus.dbg_start = 1'b1; bus.dbg_base = 32'h0;
        cyc();
        bus.dbg_start = 1'b0;
        beat(32'hB0, 1'b0); cyc();
        beat(32'hB1, 1'b0); cyc();
        beat(32'hB2, 1'b0);
        #2 nrst = 1'b0;
        #1;
        chk("arst_wready", 32'(bus.dbg_wready), 32'd0);
        chk("arst_busy", 32'(bus.dbg_busy), 32'd0);
        chk("arst_instr", bus.fetch_instr, NOP);
        chk("arst_count", 32'(bus.dbg_count), 32'd0);
        bus.dbg_wvalid = 1'b0;
        @(posedge clk);
        #1 nrst = 1'b1;
        cyc();
        chk("arst_nodone", 32'(bus.dbg_done), 32'd0);
        fetch(32'h0); cyc(); chk("arst_w0", bus.fetch_instr, 32'hB0);
        fetch(32'h4); cyc(); chk("arst_w1", bus.fetch_instr, 32'hB1);
        fetch(32'h8); cyc(); chk("arst_w2", bus.fetch_instr, 32'h33);
        bus.fetch_req = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/imem_burst.md
# imem_burst

Parametrised instruction memory for the core's fetch stage, with a debug burst-load engine sharing the same clock. Fetch is a registered, one-cycle-latency read with alignment and range checking. The debug port loads a contiguous program image from a base address using a valid/ready stream. Fetch is stalled while a load is in progress so the core never sees a partially written image.

## Interface
- XLEN, 32, instruction/data word width
- DEPTH, 256, memory depth in words (power of two, ≥4); ADDR_W = $clog2(DEPTH) derived
- NOP_INSTR, 32'h00000013, value driven on fetch_instr after reset and on fetch errors

Ports:
- clk  in  1  single clock; all state updates on posedge
- nrst  in  1  reset, asynchronous, active-low
- fetch_req  in  1  fetch request this cycle
- fetch_addr  in  32  byte address of the instruction
- fetch_valid  out  1  fetch_instr/fetch_err valid this cycle
- fetch_instr  out  XLEN  fetched instruction
- fetch_err  out  1  misaligned or out-of-range fetch
- fetch_stall  out  1  memory busy loading; requests are refused
- dbg_start  in  1  start a burst load at dbg_base
- dbg_base  in  32  byte start address of the burst
- dbg_wvalid  in  1  write beat valid
- dbg_wdata  in  XLEN  write beat data
- dbg_last  in  1  marks final beat of the burst
- dbg_wready  out  1  engine accepts a beat
- dbg_busy  out  1  load in progress
- dbg_done  out  1  one-cycle pulse at burst end
- dbg_err  out  1  bad base or truncated burst; held until next dbg_start
- dbg_count  out  ADDR_W+1  words written by the last/current burst

## Operation
- Storage: DEPTH x XLEN array, word index = byte address[ADDR_W+1:2]. Contents not reset.
- Fetch, accepted when fetch_req=1 and state=IDLE:
  - addr[1:0]≠0 or addr[31:2] ≥ DEPTH → fetch_err=1, fetch_instr=NOP_INSTR
  - otherwise fetch_instr = mem[addr[ADDR_W+1:2]], fetch_err=0
- Fetch refused (fetch_req=1, state≠IDLE): fetch_valid=0 next cycle; the core must re-issue.
- FSM states IDLE, LOAD, DONE:
  - IDLE: dbg_start=1 with aligned, in-range base → ptr=base word index, dbg_count=0, dbg_err=0 → LOAD. Bad base → dbg_err=1, dbg_count=0, dbg_done pulse, stay IDLE.
  - LOAD: dbg_wready=1. A beat (dbg_wvalid & dbg_wready) writes mem[ptr]; ptr++, dbg_count++. If dbg_last → DONE. If ptr = DEPTH-1 and not dbg_last → write, dbg_err=1, → DONE (truncated). dbg_start ignored.
  - DONE: dbg_done=1 for one cycle, dbg_wready=0 → IDLE.
- fetch_stall = dbg_busy = (state≠IDLE).
- No wrap-around: ptr never exceeds DEPTH-1.

## Timing
- Reset (nrst=0, async): state=IDLE, fetch_valid=0, fetch_instr=NOP_INSTR, fetch_err=0, dbg_done=0, dbg_err=0, dbg_count=0, dbg_wready=0, fetch_stall=0, dbg_busy=0. Reset mid-LOAD aborts; already written words remain, no dbg_done.
- Fetch latency: request in cycle N → fetch_valid/fetch_instr/fetch_err in N+1; back-to-back requests give one result per cycle. fetch_instr holds its last value when fetch_valid=0.
- dbg_start in cycle N → LOAD (dbg_wready=1) in N+1. Beat in cycle M is readable by a fetch issued in M+2 (the DONE cycle stalls fetch).
- dbg_start and fetch_req in the same IDLE cycle: fetch is served, LOAD begins next cycle.
- dbg_last beat in cycle M → dbg_done=1 in M+1 → IDLE and fetch accepted in M+2.
- dbg_wvalid while dbg_wready=0 is dropped silently.

## Test plan
- Reset: hold nrst=0 mid-cycle → all outputs at reset values immediately. Release → fetch_stall=0, fetch_instr=32'h00000013.
- Burst load base=0x40 with 4 beats 0xA0..0xA3 (last on 4th) → dbg_done one cycle after last, dbg_count=4, dbg_err=0. Fetches at 0x40,0x44,0x48,0x4C, back-to-back → 0xA0..0xA3 each one cycle later.
- Fetch during LOAD at 0x40 → fetch_stall=1, fetch_valid=0. Re-issue after DONE → valid data.
- Fetch 0x42 → fetch_err=1, NOP_INSTR. Fetch 4*DEPTH (0x400) → fetch_err=1.
- Burst base=4*(DEPTH-2) with 5 beats, no last → 2 words written, dbg_err=1, dbg_count=2, dbg_done pulse, no wrap to word 0. dbg_start base=0x41 → dbg_err=1, no write.
- Assert nrst mid-burst after 2 beats at base 0 → IDLE, no dbg_done. Words 0–1 hold new data; word 2 unchanged.
